bram_reduce: RTL and testbench

Parametrised reduction engine that scans a contiguous window of a native-port block RAM, finds the maximum or minimum word (signed or unsigned), and writes the result back into the BRAM at a programmable destination address. It sits in the PL beside the AXI BRAM Controller on the second BRAM port, with its control and status inputs driven by an AXI-lite register wrapper. It replaces the fixed 2048-word unsigned-max engine with a configurable-window, multi-mode engine.

---
 rtl/bram_reduce_if.sv | 43 ++++
 rtl/bram_reduce.sv | 208 ++++++++++++++++++++
 tb/tb_bram_reduce.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/bram_reduce_if.sv
`default_nettype none
// ============================================================================
// Module      : bram_reduce_if
// Description : Control, status and native BRAM port bundle for bram_reduce.
//               "slave" is the reduction engine's view. "master" is the view of
//               the register wrapper and BRAM side.
// Revision    : 1.0 - initial release
// ============================================================================
interface bram_reduce_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 11
);
   logic              start;
   logic              mode_min;
   logic              mode_signed;
   logic [ADDR_W-1:0] base_addr;
   logic [ADDR_W:0]   length;
   logic [ADDR_W-1:0] dest_addr;
   logic              busy;
   logic              done;
   logic              err;
   logic [DATA_W-1:0] result;
   logic [ADDR_W-1:0] result_idx;
   logic [ADDR_W-1:0] bram_addr;
   logic [DATA_W-1:0] bram_din;
   logic              bram_we;
   logic [DATA_W-1:0] bram_dout;

   modport master (
      output start, mode_min, mode_signed, base_addr, length, dest_addr,
      input  busy, done, err, result, result_idx,
      input  bram_addr, bram_din, bram_we,
      output bram_dout
   );

   modport slave (
      input  start, mode_min, mode_signed, base_addr, length, dest_addr,
      output busy, done, err, result, result_idx,
      output bram_addr, bram_din, bram_we,
      input  bram_dout
   );
endinterface
`default_nettype wire

// File: rtl/bram_reduce.sv
`default_nettype none
// ============================================================================
// Module      : bram_reduce
// Description : Scans a window of a native-port BRAM and finds the maximum or
//               minimum word (signed or unsigned). It writes the result back
//               to a destination address. Define BRAM_REDUCE_INDEX_WB_EN to
//               also write the winning window offset to dest_addr+1.
// Revision    : 1.0 - initial release
// ============================================================================
module bram_reduce #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 11,
   parameter int READ_LAT = 1
) (
   input wire           clk,
   input wire           reset,
   bram_reduce_if.slave bus
);

   localparam int CNT_W = ADDR_W + 1;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_SCAN   = 3'd1;
   localparam logic [2:0] S_DRAIN  = 3'd2;
   localparam logic [2:0] S_WR_VAL = 3'd3;
   localparam logic [2:0] S_DONE   = 3'd4;
`ifdef BRAM_REDUCE_INDEX_WB_EN
   localparam logic [2:0] S_WR_IDX = 3'd5;
`endif

   logic [2:0]        state_q, state_d;
   logic              mode_min_q, mode_min_d;
   logic              mode_signed_q, mode_signed_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [CNT_W-1:0]  len_q, len_d;
   logic [ADDR_W-1:0] dest_q, dest_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;          // addresses issued so far
   logic [ADDR_W-1:0] rd_off_q, rd_off_d;    // offset of the word now returning
   logic [DATA_W-1:0] acc_q, acc_d;
   logic [ADDR_W-1:0] acc_idx_q, acc_idx_d;
   logic              acc_vld_q, acc_vld_d;  // first word already loaded
   logic [READ_LAT:0] pipe_q, pipe_d;        // tracks reads in flight; tap READ_LAT = data valid now
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] din_q, din_d;

   logic cmp_gt, cmp_lt, cmp_better, older_pending;

   // Strict-improvement compare of the returning word against the accumulator
   assign cmp_gt = mode_signed_q ? ($signed(bus.bram_dout) > $signed(acc_q)) : (bus.bram_dout > acc_q);
   assign cmp_lt = mode_signed_q ? ($signed(bus.bram_dout) < $signed(acc_q)) : (bus.bram_dout < acc_q);
   assign cmp_better = mode_min_q ? cmp_lt : cmp_gt;
   assign older_pending = (pipe_q[READ_LAT-1:0] != '0);

   // Next-state, accumulator and BRAM port decoding
   always_comb begin
      state_d       = state_q;
      mode_min_d    = mode_min_q;
      mode_signed_d = mode_signed_q;
      base_d        = base_q;
      len_d         = len_q;
      dest_d        = dest_q;
      cnt_d         = cnt_q;
      rd_off_d      = rd_off_q;
      acc_d         = acc_q;
      acc_idx_d     = acc_idx_q;
      acc_vld_d     = acc_vld_q;
      err_d         = err_q;
      we_d          = 1'b0;
      addr_d        = addr_q;
      din_d         = din_q;
      pipe_d        = {pipe_q[READ_LAT-1:0], 1'b0};

      if (pipe_q[READ_LAT]) begin
         if (!acc_vld_q || cmp_better) begin
            acc_d     = bus.bram_dout;
            acc_idx_d = rd_off_q;
         end
         acc_vld_d = 1'b1;
         rd_off_d  = rd_off_q + ADDR_W'(1);
      end

      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               mode_min_d    = bus.mode_min;
               mode_signed_d = bus.mode_signed;
               base_d        = bus.base_addr;
               len_d         = bus.length;
               dest_d        = bus.dest_addr;
               cnt_d         = '0;
               rd_off_d      = '0;
               acc_d         = '0;
               acc_idx_d     = '0;
               acc_vld_d     = 1'b0;
               err_d         = 1'b0;
               state_d       = S_SCAN;
            end
         end
         S_SCAN: begin
            if (len_q == '0) begin
               // Empty window: report an error without touching the BRAM
               err_d   = 1'b1;
               state_d = S_DONE;
            end else begin
               addr_d    = base_q + cnt_q[ADDR_W-1:0];
               pipe_d[0] = 1'b1;
               cnt_d     = cnt_q + CNT_W'(1);
               if (cnt_q + CNT_W'(1) == len_q) begin
                  state_d = S_DRAIN;
               end
            end
         end
         S_DRAIN: begin
            // Leave when the final word is being compared this cycle
            if (pipe_q[READ_LAT] && !older_pending) begin
               we_d    = 1'b1;
               addr_d  = dest_q;
               din_d   = acc_d;
               state_d = S_WR_VAL;
            end
         end
         S_WR_VAL: begin
`ifdef BRAM_REDUCE_INDEX_WB_EN
            we_d    = 1'b1;
            addr_d  = dest_q + ADDR_W'(1);
            din_d   = DATA_W'(acc_idx_q);
            state_d = S_WR_IDX;
`else
            state_d = S_DONE;
`endif
         end
`ifdef BRAM_REDUCE_INDEX_WB_EN
         S_WR_IDX: begin
            state_d = S_DONE;
         end
`endif
         S_DONE: begin
            if (!bus.start) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
      done_d = (state_d == S_DONE);
   end

   // State and output registers; reset abandons any operation without a write
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= S_IDLE;
         mode_min_q    <= 1'b0;
         mode_signed_q <= 1'b0;
         base_q        <= '0;
         len_q         <= '0;
         dest_q        <= '0;
         cnt_q         <= '0;
         rd_off_q      <= '0;
         acc_q         <= '0;
         acc_idx_q     <= '0;
         acc_vld_q     <= 1'b0;
         pipe_q        <= '0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         err_q         <= 1'b0;
         we_q          <= 1'b0;
         addr_q        <= '0;
         din_q         <= '0;
      end else begin
         state_q       <= state_d;
         mode_min_q    <= mode_min_d;
         mode_signed_q <= mode_signed_d;
         base_q        <= base_d;
         len_q         <= len_d;
         dest_q        <= dest_d;
         cnt_q         <= cnt_d;
         rd_off_q      <= rd_off_d;
         acc_q         <= acc_d;
         acc_idx_q     <= acc_idx_d;
         acc_vld_q     <= acc_vld_d;
         pipe_q        <= pipe_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         err_q         <= err_d;
         we_q          <= we_d;
         addr_q        <= addr_d;
         din_q         <= din_d;
      end
   end

   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.err        = err_q;
   assign bus.result     = acc_q;
   assign bus.result_idx = acc_idx_q;
   assign bus.bram_addr  = addr_q;
   assign bus.bram_din   = din_q;
   assign bus.bram_we    = we_q;

endmodule
`default_nettype wire

// File: tb/tb_bram_reduce.sv
`default_nettype none
// ============================================================================
// Module      : tb_bram_reduce
// Description : Self-checking bench for bram_reduce with a behavioural BRAM
//               (DATA_W=32, ADDR_W=11, READ_LAT=1). Honours
//               BRAM_REDUCE_INDEX_WB_EN for the index write-back.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bram_reduce;

   localparam int DW = 32;
   localparam int AW = 11;
   localparam int RL = 1;
`ifdef BRAM_REDUCE_INDEX_WB_EN
   localparam int WB = 1;
`else
   localparam int WB = 0;
`endif

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   bram_reduce_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

   bram_reduce #(.DATA_W(DW), .ADDR_W(AW), .READ_LAT(RL)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Behavioural BRAM with a backdoor write port for preloading
   logic [DW-1:0] mem [0:(1<<AW)-1];
   logic [DW-1:0] rd_pipe [0:RL-1];
   logic          tb_wr;
   logic [AW-1:0] tb_addr;
   logic [DW-1:0] tb_data;

   always @(posedge clk) begin
      if (tb_wr) mem[tb_addr] <= tb_data;
      else if (bus.bram_we) mem[bus.bram_addr] <= bus.bram_din;
      rd_pipe[0] <= mem[bus.bram_addr];
      for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
   end
   assign bus.bram_dout = rd_pipe[RL-1];

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic poke(input int a, input logic [DW-1:0] d);
      tb_addr = AW'(a);
      tb_data = d;
      tb_wr   = 1'b1;
      @(posedge clk); #1;
      tb_wr   = 1'b0;
   endtask

   // One operation; edge k is the first edge that sees start. n counts edges after k.
   task automatic run_op(input logic [AW-1:0] base, input logic [AW:0] len,
                         input logic [AW-1:0] dest, input logic mn, input logic sg,
                         input logic hold,
                         output int done_n, output int we_cnt, output logic addr_ok,
                         output logic busy_ok, output logic [DW-1:0] res,
                         output logic [AW-1:0] idx, output logic er);
      @(posedge clk); #1;
      bus.base_addr   = base;
      bus.length      = len;
      bus.dest_addr   = dest;
      bus.mode_min    = mn;
      bus.mode_signed = sg;
      bus.start       = 1'b1;
      done_n  = -1;
      we_cnt  = 0;
      addr_ok = 1'b1;
      @(posedge clk); #1;
      busy_ok = bus.busy;
      if (!hold) bus.start = 1'b0;
      res = '0; idx = '0; er = 1'b0;
      for (int n = 1; n <= 2200; n++) begin
         @(posedge clk); #1;
         if (n <= int'(len) && bus.bram_addr !== AW'(int'(base) + n - 1)) addr_ok = 1'b0;
         if (bus.bram_we) we_cnt++;
         if (bus.done) begin
            done_n = n;
            res = bus.result;
            idx = bus.result_idx;
            er  = bus.err;
            if (bus.busy) busy_ok = 1'b0;
            break;
         end
         if (!bus.busy) busy_ok = 1'b0;
      end
   endtask

   typedef struct {
      logic [AW-1:0] base;
      logic [AW:0]   len;
      logic [AW-1:0] dest;
      logic          mn;
      logic          sg;
      logic [DW-1:0] exp_res;
      logic [AW-1:0] exp_idx;
      logic          exp_err;
   } vec_t;

   localparam int NV = 11;
   vec_t vecs [NV];

   initial begin
      int done_n, we_cnt, exp_dn, cnt_we, cnt_busy;
      logic addr_ok, busy_ok, er;
      logic [DW-1:0] res;
      logic [AW-1:0] idx;

      //            base   len    dest  min  sgn  result        idx    err
      vecs[0]  = '{11'd100, 12'd4, 11'd400, 1'b1, 1'b1, 32'hFFFFFFFD, 11'd1, 1'b0};
      vecs[1]  = '{11'd100, 12'd4, 11'd402, 1'b0, 1'b0, 32'hFFFFFFFD, 11'd1, 1'b0};
      vecs[2]  = '{11'd100, 12'd4, 11'd404, 1'b0, 1'b1, 32'h00000007, 11'd2, 1'b0};
      vecs[3]  = '{11'd100, 12'd4, 11'd103, 1'b1, 1'b0, 32'h00000005, 11'd0, 1'b0};
      vecs[4]  = '{11'd200, 12'd6, 11'd406, 1'b0, 1'b0, 32'hFFFFFFFF, 11'd5, 1'b0};
      vecs[5]  = '{11'd200, 12'd6, 11'd408, 1'b0, 1'b1, 32'h0000000A, 11'd0, 1'b0};
      vecs[6]  = '{11'd200, 12'd6, 11'd410, 1'b1, 1'b1, 32'h80000000, 11'd3, 1'b0};
      vecs[7]  = '{11'd200, 12'd6, 11'd412, 1'b1, 1'b0, 32'h00000002, 11'd4, 1'b0};
      vecs[8]  = '{11'd2046, 12'd4, 11'd420, 1'b0, 1'b0, 32'h00000099, 11'd1, 1'b0};
      vecs[9]  = '{11'd101, 12'd1, 11'd430, 1'b1, 1'b1, 32'hFFFFFFFD, 11'd0, 1'b0};
      vecs[10] = '{11'd300, 12'd0, 11'd440, 1'b0, 1'b0, 32'h00000000, 11'd0, 1'b1};

      reset = 1'b1;
      tb_wr = 1'b0; tb_addr = '0; tb_data = '0;
      bus.start = 1'b0; bus.mode_min = 1'b0; bus.mode_signed = 1'b0;
      bus.base_addr = '0; bus.length = '0; bus.dest_addr = '0;

      poke(100, 32'd5);  poke(101, 32'hFFFFFFFD); poke(102, 32'd7); poke(103, 32'hFFFFFFFD);
      poke(200, 32'd10); poke(201, 32'd3); poke(202, 32'd10);
      poke(203, 32'h80000000); poke(204, 32'd2); poke(205, 32'hFFFFFFFF);
      poke(2046, 32'h11); poke(2047, 32'h99); poke(0, 32'h42); poke(1, 32'h99);
      poke(440, 32'h5A5A5A5A); poke(500, 32'hA5A5A5A5);

      chk("rst_busy", 64'(bus.busy), 0);
      chk("rst_done", 64'(bus.done), 0);
      chk("rst_err", 64'(bus.err), 0);
      chk("rst_result", 64'(bus.result), 0);
      chk("rst_idx", 64'(bus.result_idx), 0);
      chk("rst_addr", 64'(bus.bram_addr), 0);
      chk("rst_din", 64'(bus.bram_din), 0);
      chk("rst_we", 64'(bus.bram_we), 0);
      reset = 1'b0;

      for (int i = 0; i < NV; i++) begin
         run_op(vecs[i].base, vecs[i].len, vecs[i].dest, vecs[i].mn, vecs[i].sg, 1'b0,
                done_n, we_cnt, addr_ok, busy_ok, res, idx, er);
         exp_dn = (vecs[i].len == 0) ? 1 : int'(vecs[i].len) + RL + 2 + WB;
         chk($sformatf("v%0d_result", i), 64'(res), 64'(vecs[i].exp_res));
         chk($sformatf("v%0d_idx", i), 64'(idx), 64'(vecs[i].exp_idx));
         chk($sformatf("v%0d_err", i), 64'(er), 64'(vecs[i].exp_err));
         chk($sformatf("v%0d_done_edge", i), 64'(done_n), 64'(exp_dn));
         chk($sformatf("v%0d_we_pulses", i), 64'(we_cnt), (vecs[i].len == 0) ? 64'd0 : 64'(1 + WB));
         chk($sformatf("v%0d_addr_seq", i), 64'(addr_ok), 1);
         chk($sformatf("v%0d_busy", i), 64'(busy_ok), 1);
         if (vecs[i].len != 0)
            chk($sformatf("v%0d_mem_dest", i), 64'(mem[vecs[i].dest]), 64'(vecs[i].exp_res));
         else
            chk($sformatf("v%0d_mem_untouched", i), 64'(mem[vecs[i].dest]), 64'h5A5A5A5A);
`ifdef BRAM_REDUCE_INDEX_WB_EN
         if (vecs[i].len != 0)
            chk($sformatf("v%0d_mem_idx", i), 64'(mem[vecs[i].dest + 11'd1]), 64'(vecs[i].exp_idx));
`endif
      end

      // Handshake: done stays high while start is held, falls one edge after it drops
      run_op(11'd200, 12'd6, 11'd450, 1'b0, 1'b1, 1'b1,
             done_n, we_cnt, addr_ok, busy_ok, res, idx, er);
      chk("hs_done_edge", 64'(done_n), 64'(6 + RL + 2 + WB));
      for (int c = 0; c < 4; c++) begin
         @(posedge clk); #1;
         chk($sformatf("hs_done_held%0d", c), 64'(bus.done), 1);
         chk($sformatf("hs_result_held%0d", c), 64'(bus.result), 64'h0000000A);
      end
      bus.start = 1'b0;
      @(posedge clk); #1;
      chk("hs_done_fall", 64'(bus.done), 0);

      // Reset in the middle of a scan: no write, block returns idle
      @(posedge clk); #1;
      bus.base_addr = '0; bus.length = 12'd100; bus.dest_addr = 11'd500;
      bus.mode_min = 1'b0; bus.mode_signed = 1'b0; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      chk("mid_busy_before", 64'(bus.busy), 1);
      reset = 1'b1;
      @(posedge clk); #1;
      chk("mid_rst_busy", 64'(bus.busy), 0);
      chk("mid_rst_we", 64'(bus.bram_we), 0);
      chk("mid_rst_done", 64'(bus.done), 0);
      reset = 1'b0;
      cnt_we = 0; cnt_busy = 0;
      repeat (150) begin
         @(posedge clk); #1;
         if (bus.bram_we) cnt_we++;
         if (bus.busy) cnt_busy++;
      end
      chk("mid_no_write", 64'(cnt_we), 0);
      chk("mid_stays_idle", 64'(cnt_busy), 0);
      chk("mid_dest_untouched", 64'(mem[500]), 64'hA5A5A5A5);
      run_op(vecs[0].base, vecs[0].len, 11'd460, vecs[0].mn, vecs[0].sg, 1'b0,
             done_n, we_cnt, addr_ok, busy_ok, res, idx, er);
      chk("post_rst_result", 64'(res), 64'hFFFFFFFD);
      chk("post_rst_done_edge", 64'(done_n), 64'(4 + RL + 2 + WB));

      // Full-depth unsigned max with the winner in the last word
      for (int a = 0; a < 2047; a++) poke(a, $urandom() & 32'h7FFFFFFF);
      poke(2047, 32'hFFFFFFFF);
      run_op(11'd0, 12'd2048, 11'd0, 1'b0, 1'b0, 1'b0,
             done_n, we_cnt, addr_ok, busy_ok, res, idx, er);
      chk("full_result", 64'(res), 64'hFFFFFFFF);
      chk("full_idx", 64'(idx), 64'd2047);
      chk("full_done_edge", 64'(done_n), 64'(2048 + RL + 2 + WB));
      chk("full_addr_seq", 64'(addr_ok), 1);
      chk("full_mem0", 64'(mem[0]), 64'hFFFFFFFF);
`ifdef BRAM_REDUCE_INDEX_WB_EN
      chk("full_mem1_idx", 64'(mem[1]), 64'd2047);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
